// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: pixel color layout, nominal line timing and
// receiver decision points (all in nanoseconds), and the decoder state type.
package ws2812_pkg;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } color_t;

    localparam int T0H   = 400;
    localparam int T1H   = 800;
    localparam int T0L   = 850;
    localparam int T1L   = 450;
    localparam int LATCH = 50_000;

    localparam int T_MIN_NS    = 150;
    localparam int T_THRESH_NS = 600;
    localparam int T_MAX_H_NS  = 2_000;

    localparam int BITS_PER_PIXEL = 24;

    typedef enum logic [1:0] {SYNC, LOW, HIGH} dec_state_t;

    // Bits arrive green, red, blue on the wire.
    function automatic color_t grb_to_color(input logic [23:0] grb);
        return '{red: grb[15:8], green: grb[23:16], blue: grb[7:0]};
    endfunction

endpackage

// File: rtl/ws2812_bit_decoder.sv
// Synchronizes the WS2812 line and classifies each high pulse as a data bit,
// a latch (long low) or a protocol error.
module ws2812_bit_decoder
    import ws2812_pkg::*;
#(
    parameter int CLK_FREQ = 20_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic bit_start,
    output logic bit_valid,
    output logic bit_value,
    output logic latch,
    output logic err
);

    localparam int T_MIN     = $rtoi(real'(CLK_FREQ) * T_MIN_NS / 1.0e9);
    localparam int T_THRESH  = $rtoi(real'(CLK_FREQ) * T_THRESH_NS / 1.0e9);
    localparam int T_MAX_H   = $rtoi(real'(CLK_FREQ) * T_MAX_H_NS / 1.0e9);
    localparam int LATCH_CYC = $rtoi(real'(CLK_FREQ) * LATCH / 1.0e9);

    localparam int LCNT_W = $clog2(LATCH_CYC + 1);
    localparam int HCNT_W = $clog2(T_MAX_H + 1);

    localparam logic [LCNT_W-1:0] LOW_SAT   = LCNT_W'(LATCH_CYC);
    localparam logic [LCNT_W-1:0] LOW_LAST  = LCNT_W'(LATCH_CYC - 1);
    localparam logic [HCNT_W-1:0] HIGH_MIN  = HCNT_W'(T_MIN);
    localparam logic [HCNT_W-1:0] HIGH_THR  = HCNT_W'(T_THRESH);
    localparam logic [HCNT_W-1:0] HIGH_SAT  = HCNT_W'(T_MAX_H);
    localparam logic [HCNT_W-1:0] HIGH_LAST = HCNT_W'(T_MAX_H - 1);

    logic              din_m;
    logic              din_s;
    dec_state_t        state;
    logic [LCNT_W-1:0] low_cnt;
    logic [HCNT_W-1:0] high_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            din_m     <= 1'b0;
            din_s     <= 1'b0;
            state     <= SYNC;
            low_cnt   <= '0;
            high_cnt  <= '0;
            bit_start <= 1'b0;
            bit_valid <= 1'b0;
            bit_value <= 1'b0;
            latch     <= 1'b0;
            err       <= 1'b0;
        end else begin
            din_m     <= din;
            din_s     <= din_m;
            bit_start <= 1'b0;
            bit_valid <= 1'b0;
            latch     <= 1'b0;
            err       <= 1'b0;
            case (state)
                // Hunt for a quiet line before trusting any edge; no latch strobe here.
                SYNC: begin
                    if (din_s) begin
                        low_cnt <= '0;
                    end else if (low_cnt >= LOW_LAST) begin
                        low_cnt <= LOW_SAT;
                        state   <= LOW;
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (din_s) begin
                        state     <= HIGH;
                        high_cnt  <= HCNT_W'(1);
                        low_cnt   <= '0;
                        bit_start <= 1'b1;
                    end else if (low_cnt != LOW_SAT) begin
                        low_cnt <= low_cnt + 1'b1;
                        if (low_cnt == LOW_LAST) latch <= 1'b1;
                    end
                end
                HIGH: begin
                    if (!din_s) begin
                        // The falling-edge sample is itself the first low cycle.
                        low_cnt <= LCNT_W'(1);
                        if (high_cnt < HIGH_MIN) begin
                            err   <= 1'b1;
                            state <= SYNC;
                        end else begin
                            bit_valid <= 1'b1;
                            bit_value <= (high_cnt >= HIGH_THR);
                            state     <= LOW;
                        end
                    end else if (high_cnt >= HIGH_LAST) begin
                        high_cnt <= HIGH_SAT;
                        low_cnt  <= '0;
                        err      <= 1'b1;
                        state    <= SYNC;
                    end else begin
                        high_cnt <= high_cnt + 1'b1;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: assembles decoded bits into GRB pixels, numbers them per
// frame and reports frame completion, overflow and protocol errors.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int CLK_FREQ = 20_000_000,
    parameter int NUM_LEDS = 256
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       din,
    output logic       pixel_valid,
    output color_t     pixel,
    output logic [8:0] pixel_index,
    output logic       frame_done,
    output logic [8:0] pixel_count,
    output logic       err,
    output logic       overflow,
    output logic       busy
);

    localparam logic [8:0] MAX_IDX  = 9'(NUM_LEDS);
    localparam logic [4:0] LAST_BIT = 5'(BITS_PER_PIXEL - 1);

    logic        bit_start;
    logic        bit_valid;
    logic        bit_value;
    logic        latch;
    logic        dec_err;
    logic [4:0]  bit_cnt;
    logic [22:0] shift_q;
    logic [23:0] word;

    ws2812_bit_decoder #(.CLK_FREQ(CLK_FREQ)) u_decoder (
        .clock    (clock),
        .reset    (reset),
        .din      (din),
        .bit_start(bit_start),
        .bit_valid(bit_valid),
        .bit_value(bit_value),
        .latch    (latch),
        .err      (dec_err)
    );

    assign word = {shift_q, bit_value};

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt     <= '0;
            shift_q     <= '0;
            pixel_valid <= 1'b0;
            pixel       <= '0;
            pixel_index <= '0;
            frame_done  <= 1'b0;
            pixel_count <= '0;
            err         <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            if (frame_done || err) overflow <= 1'b0;
            if (bit_start) busy <= 1'b1;

            if (latch) begin
                bit_cnt     <= '0;
                pixel_index <= '0;
                busy        <= 1'b0;
                // A partial pixel closes the frame as an error; its bits are dropped.
                if (bit_cnt != '0) begin
                    err         <= 1'b1;
                    frame_done  <= 1'b1;
                    pixel_count <= pixel_index;
                end else if (pixel_index != '0) begin
                    frame_done  <= 1'b1;
                    pixel_count <= pixel_index;
                end
            end else if (dec_err) begin
                err         <= 1'b1;
                bit_cnt     <= '0;
                pixel_index <= '0;
                busy        <= 1'b0;
            end else begin
                if (pixel_valid) pixel_index <= pixel_index + 9'd1;
                if (bit_valid) begin
                    shift_q <= word[22:0];
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        // The index saturates at NUM_LEDS, so it also serves as pixel_count.
                        if (pixel_index >= MAX_IDX) begin
                            overflow <= 1'b1;
                        end else begin
                            pixel_valid <= 1'b1;
                            pixel       <= grb_to_color(word);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
            end
        end
    end

endmodule
